// File: rtl/matrix_stream_loader_if.sv
// Bundle of the coefficient stream, the packed A/B matrix outputs and the
// loader's state debug view. Optional framing signals are present only when
// MATRIX_LOADER_FRAME_CHECK_EN is defined.
//
// Handshake rules:
//   - A word transfers on a rising clock edge where s_valid and s_ready are
//     both 1.
//   - A/B transfer on a rising clock edge where m_valid and m_ready are both 1.
//   - s_ready and m_valid come from registers only. They never depend
//     combinationally on s_valid or m_ready.
//   - A and B are meaningful only while m_valid is 1. They hold steady until
//     the handshake completes.
interface matrix_stream_loader_if #(
   parameter int N = 32,
   parameter int P = 4
);
   logic [N-1:0]     s_data;
   logic             s_valid;
   logic             s_ready;
   logic [P*P*N-1:0] A;
   logic [P*P*N-1:0] B;
   logic             m_valid;
   logic             m_ready;
   logic [1:0]       dbg_state;
`ifdef MATRIX_LOADER_FRAME_CHECK_EN
   logic             s_last;
   logic             err_frame;
`endif

   // Loader side
   modport slave (
`ifdef MATRIX_LOADER_FRAME_CHECK_EN
      input  s_last,
      output err_frame,
`endif
      input  s_data, s_valid, m_ready,
      output s_ready, A, B, m_valid, dbg_state
   );

   // Producer/consumer side
   modport master (
`ifdef MATRIX_LOADER_FRAME_CHECK_EN
      output s_last,
      input  err_frame,
`endif
      output s_data, s_valid, m_ready,
      input  s_ready, A, B, m_valid, dbg_state
   );
endinterface

// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader: takes a word-serial stream of signed fixed-point
// coefficients. It packs matrix A and then matrix B, each row-major, onto flat
// P*P*N buses. It then presents the pair with m_valid until the consumer
// accepts it.
//
// Optional feature macro: MATRIX_LOADER_FRAME_CHECK_EN
//   When defined, s_last must mark the final B word of each frame. Two cases
//   are framing errors: s_last arriving early, or the final B word arriving
//   without s_last. On a framing error the word is dropped, err_frame pulses,
//   and loading restarts at A element 0.
module matrix_stream_loader #(
   parameter int N = 32,
   parameter int Q = 18,
   parameter int P = 4
) (
   input logic                    clk,
   input logic                    reset,
   matrix_stream_loader_if.slave  bus
);
   localparam int ELEMS = P * P;
   localparam int IDXW  = (ELEMS > 1) ? $clog2(ELEMS) : 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(ELEMS - 1);

   // Parameter sanity: Q only describes the data, but it must still fit.
   // P*P must be a power of two so the index counter wraps on its own.
   if (Q < 0 || Q >= N) begin : g_q_check
      $error("matrix_stream_loader: Q must lie in [0, N-1]");
   end
   if ((ELEMS & (ELEMS - 1)) != 0) begin : g_p_check
      $error("matrix_stream_loader: P*P must be a power of 2");
   end

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      FULL   = 2'd2
   } state_t;

   state_t           state_q;
   logic [IDXW-1:0]  idx_q;
   logic [IDXW-1:0]  idx_d;
   logic [P*P*N-1:0] a_q;
   logic [P*P*N-1:0] b_q;
   logic             m_valid_q;
   logic             s_ready_q;
   logic             beat_d;
   logic             at_last_d;
   logic             err_d;

   assign beat_d    = bus.s_valid & s_ready_q;
   assign at_last_d = (idx_q == IDX_LAST);
   assign idx_d     = idx_q + 1'b1;

`ifdef MATRIX_LOADER_FRAME_CHECK_EN
   logic err_frame_q;

   // A frame is bad if s_last arrives on any word except the final B word,
   // or if the final B word arrives without s_last.
   assign err_d = beat_d &&
                  (((state_q == LOAD_A) && bus.s_last) ||
                   ((state_q == LOAD_B) && (bus.s_last != at_last_d)));

   // err_frame is high for exactly one cycle after each framing error.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) err_frame_q <= 1'b0;
      else        err_frame_q <= err_d;
   end

   assign bus.err_frame = err_frame_q;
`else
   assign err_d = 1'b0;
`endif

   // Loader FSM: moves the element index, writes matrix storage and drives
   // the registered handshake outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= LOAD_A;
         idx_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         m_valid_q <= 1'b0;
         s_ready_q <= 1'b1;
      end else begin
         case (state_q)
            LOAD_A: begin
               if (err_d) begin
                  idx_q <= '0;
               end else if (beat_d) begin
                  for (int e = 0; e < ELEMS; e++) begin
                     if (idx_q == IDXW'(e)) a_q[e*N +: N] <= bus.s_data;
                  end
                  idx_q <= idx_d;
                  if (at_last_d) state_q <= LOAD_B;
               end
            end
            LOAD_B: begin
               if (err_d) begin
                  idx_q   <= '0;
                  state_q <= LOAD_A;
               end else if (beat_d) begin
                  for (int e = 0; e < ELEMS; e++) begin
                     if (idx_q == IDXW'(e)) b_q[e*N +: N] <= bus.s_data;
                  end
                  idx_q <= idx_d;
                  if (at_last_d) begin
                     state_q   <= FULL;
                     s_ready_q <= 1'b0;
                     m_valid_q <= 1'b1;
                  end
               end
            end
            FULL: begin
               // Storage is frozen here. Incoming words are ignored.
               if (bus.m_ready) begin
                  state_q   <= LOAD_A;
                  idx_q     <= '0;
                  s_ready_q <= 1'b1;
                  m_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= LOAD_A;
               idx_q     <= '0;
               s_ready_q <= 1'b1;
               m_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.s_ready   = s_ready_q;
   assign bus.m_valid   = m_valid_q;
   assign bus.A         = a_q;
   assign bus.B         = b_q;
   assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed testbench for matrix_stream_loader (N=32, P=4). Inputs change 1ns
// after the rising edge, and outputs are sampled at the same point.
module tb_matrix_stream_loader;
   localparam int N = 32;
   localparam int P = 4;
   localparam int E = P * P;
   localparam int W = P * P * N;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   matrix_stream_loader_if #(.N(N), .P(P)) bus ();

   matrix_stream_loader #(.N(N), .Q(18), .P(P)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_fail = 0;

   logic [N-1:0] exp_q[$];
   logic [W-1:0] mdl_a = '0;
   logic [W-1:0] mdl_b = '0;
   logic         early_mv;
   int           cyc_cnt;

   // Drives a 2*E word frame from exp_q, optionally with a one-cycle gap
   // between words, and mirrors each word into the expected matrices.
   task automatic drive_frame(input bit gaps);
      early_mv = 1'b0;
      cyc_cnt  = 0;
      for (int i = 0; i < 2*E; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = exp_q[i];
`ifdef MATRIX_LOADER_FRAME_CHECK_EN
         bus.s_last  = (i == 2*E-1);
`endif
         if (bus.m_valid) early_mv = 1'b1;
         @(posedge clk); #1;
         cyc_cnt++;
         if (i < E) mdl_a[i*N +: N] = exp_q[i];
         else       mdl_b[(i-E)*N +: N] = exp_q[i];
         if (gaps && i != 2*E-1) begin
            bus.s_valid = 1'b0;
            bus.s_data  = 32'hBAD0_0000 + i;
`ifdef MATRIX_LOADER_FRAME_CHECK_EN
            bus.s_last  = 1'b1;
`endif
            if (bus.m_valid) early_mv = 1'b1;
            @(posedge clk); #1;
            cyc_cnt++;
         end
      end
      bus.s_valid = 1'b0;
`ifdef MATRIX_LOADER_FRAME_CHECK_EN
      bus.s_last  = 1'b0;
`endif
   endtask

   task automatic handshake();
      bus.m_ready = 1'b1;
      @(posedge clk); #1;
      bus.m_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (bus.A !== '0) begin n_fail++; $display("FAIL reset_A got %h exp 0", bus.A); end
      n_cmp++; if (bus.B !== '0) begin n_fail++; $display("FAIL reset_B got %h exp 0", bus.B); end
      n_cmp++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b exp 0", bus.m_valid); end
      reset = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got %b exp 1", bus.s_ready); end
      n_cmp++; if (bus.dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", bus.dbg_state); end
`ifdef MATRIX_LOADER_FRAME_CHECK_EN
      n_cmp++; if (bus.err_frame !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", bus.err_frame); end
`endif
   endtask

   task automatic test_identity();
      exp_q.delete();
      for (int i = 0; i < E; i++) exp_q.push_back((i / P == i % P) ? 32'h0004_0000 : 32'h0);
      for (int i = 0; i < E; i++) exp_q.push_back(32'(i + 1));
      drive_frame(1'b0);
      n_cmp++; if (early_mv !== 1'b0) begin n_fail++; $display("FAIL id_early_m_valid got %b exp 0", early_mv); end
      n_cmp++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL id_m_valid got %b exp 1", bus.m_valid); end
      n_cmp++; if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL id_s_ready got %b exp 0", bus.s_ready); end
      n_cmp++; if (bus.A[31:0] !== 32'h0004_0000) begin n_fail++; $display("FAIL id_a00 got %h exp 00040000", bus.A[31:0]); end
      n_cmp++; if (bus.A[191:160] !== 32'h0004_0000) begin n_fail++; $display("FAIL id_a11 got %h exp 00040000", bus.A[191:160]); end
      n_cmp++; if (bus.A[63:32] !== 32'h0) begin n_fail++; $display("FAIL id_a01 got %h exp 0", bus.A[63:32]); end
      n_cmp++; if (bus.B[31:0] !== 32'd1) begin n_fail++; $display("FAIL id_b00 got %h exp 1", bus.B[31:0]); end
      n_cmp++; if (bus.B[511:480] !== 32'd16) begin n_fail++; $display("FAIL id_b33 got %h exp 16", bus.B[511:480]); end
      n_cmp++; if (bus.A !== mdl_a) begin n_fail++; $display("FAIL id_A got %h exp %h", bus.A, mdl_a); end
      n_cmp++; if (bus.B !== mdl_b) begin n_fail++; $display("FAIL id_B got %h exp %h", bus.B, mdl_b); end
   endtask

   task automatic test_hold();
      bus.m_ready = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_data  = 32'hDEAD_BEEF;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         n_cmp++; if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b1) begin
            n_fail++; $display("FAIL hold_cycle%0d s_ready=%b m_valid=%b exp 0/1", c, bus.s_ready, bus.m_valid);
         end
      end
      n_cmp++; if (bus.A !== mdl_a) begin n_fail++; $display("FAIL hold_A got %h exp %h", bus.A, mdl_a); end
      n_cmp++; if (bus.B !== mdl_b) begin n_fail++; $display("FAIL hold_B got %h exp %h", bus.B, mdl_b); end
      handshake();
      bus.s_valid = 1'b0;
      n_cmp++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_m_valid got %b exp 0", bus.m_valid); end
      n_cmp++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_s_ready got %b exp 1", bus.s_ready); end
      n_cmp++; if (bus.A !== mdl_a || bus.B !== mdl_b) begin n_fail++; $display("FAIL hold_release_AB A=%h B=%h unchanged expected", bus.A, bus.B); end
   endtask

   task automatic test_gaps();
      exp_q.delete();
      for (int i = 0; i < E; i++) exp_q.push_back(32'h1000_0000 + i);
      for (int i = 0; i < E; i++) exp_q.push_back(32'hFFFF_FFFF - i);
      drive_frame(1'b1);
      n_cmp++; if (early_mv !== 1'b0) begin n_fail++; $display("FAIL gap_early_m_valid got %b exp 0 (after %0d cycles)", early_mv, cyc_cnt); end
      n_cmp++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL gap_m_valid got %b exp 1", bus.m_valid); end
      n_cmp++; if (bus.A !== mdl_a) begin n_fail++; $display("FAIL gap_A got %h exp %h", bus.A, mdl_a); end
      n_cmp++; if (bus.B !== mdl_b) begin n_fail++; $display("FAIL gap_B got %h exp %h", bus.B, mdl_b); end
      handshake();
      n_cmp++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL gap_release got %b exp 0", bus.m_valid); end
   endtask

   task automatic test_reset_mid();
      exp_q.delete();
      for (int i = 0; i < E; i++) exp_q.push_back(32'h0001_0000 * (i + 1));
      for (int i = 0; i < E; i++) exp_q.push_back(32'h8000_0000 | i);
      for (int i = 0; i < 7; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 32'h7777_0000 + i;
         @(posedge clk); #1;
      end
      bus.s_valid = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      mdl_a = '0;
      mdl_b = '0;
      n_cmp++; if (bus.A !== '0) begin n_fail++; $display("FAIL rstmid_A got %h exp 0", bus.A); end
      n_cmp++; if (bus.B !== '0) begin n_fail++; $display("FAIL rstmid_B got %h exp 0", bus.B); end
      n_cmp++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_m_valid got %b exp 0", bus.m_valid); end
      n_cmp++; if (bus.dbg_state !== 2'd0) begin n_fail++; $display("FAIL rstmid_state got %0d exp 0", bus.dbg_state); end
      #3;
      reset = 1'b1;
      @(posedge clk); #1;
      drive_frame(1'b0);
      n_cmp++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_frame_m_valid got %b exp 1", bus.m_valid); end
      n_cmp++; if (bus.A !== mdl_a) begin n_fail++; $display("FAIL rstmid_frame_A got %h exp %h", bus.A, mdl_a); end
      n_cmp++; if (bus.B !== mdl_b) begin n_fail++; $display("FAIL rstmid_frame_B got %h exp %h", bus.B, mdl_b); end
      handshake();
   endtask

`ifdef MATRIX_LOADER_FRAME_CHECK_EN
   task automatic test_frame_check();
      // s_last on beat 20: beats 1..19 land, beat 20 is dropped
      for (int i = 0; i < 20; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 32'h5500_0000 + i;
         bus.s_last  = (i == 19);
         @(posedge clk); #1;
         if (i < E) mdl_a[i*N +: N] = 32'h5500_0000 + i;
         else if (i < 19) mdl_b[(i-E)*N +: N] = 32'h5500_0000 + i;
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      n_cmp++; if (bus.err_frame !== 1'b1) begin n_fail++; $display("FAIL early_last_err got %b exp 1", bus.err_frame); end
      n_cmp++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL early_last_m_valid got %b exp 0", bus.m_valid); end
      n_cmp++; if (bus.dbg_state !== 2'd0) begin n_fail++; $display("FAIL early_last_state got %0d exp 0", bus.dbg_state); end
      n_cmp++; if (bus.A !== mdl_a || bus.B !== mdl_b) begin n_fail++; $display("FAIL early_last_AB A=%h B=%h exp A=%h B=%h", bus.A, bus.B, mdl_a, mdl_b); end
      @(posedge clk); #1;
      n_cmp++; if (bus.err_frame !== 1'b0) begin n_fail++; $display("FAIL early_last_pulse got %b exp 0", bus.err_frame); end
      exp_q.delete();
      for (int i = 0; i < 2*E; i++) exp_q.push_back(32'h6600_0000 + i);
      drive_frame(1'b0);
      n_cmp++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL recover_m_valid got %b exp 1", bus.m_valid); end
      n_cmp++; if (bus.err_frame !== 1'b0) begin n_fail++; $display("FAIL recover_err got %b exp 0", bus.err_frame); end
      n_cmp++; if (bus.A !== mdl_a || bus.B !== mdl_b) begin n_fail++; $display("FAIL recover_AB A=%h B=%h exp A=%h B=%h", bus.A, bus.B, mdl_a, mdl_b); end
      handshake();
      // Final B word without s_last: the word is dropped and no m_valid is raised
      for (int i = 0; i < 2*E; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 32'h7700_0000 + i;
         bus.s_last  = 1'b0;
         @(posedge clk); #1;
         if (i < E) mdl_a[i*N +: N] = 32'h7700_0000 + i;
         else if (i < 2*E-1) mdl_b[(i-E)*N +: N] = 32'h7700_0000 + i;
      end
      bus.s_valid = 1'b0;
      n_cmp++; if (bus.err_frame !== 1'b1) begin n_fail++; $display("FAIL no_last_err got %b exp 1", bus.err_frame); end
      n_cmp++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL no_last_m_valid got %b exp 0", bus.m_valid); end
      n_cmp++; if (bus.A !== mdl_a || bus.B !== mdl_b) begin n_fail++; $display("FAIL no_last_AB A=%h B=%h exp A=%h B=%h", bus.A, bus.B, mdl_a, mdl_b); end
      @(posedge clk); #1;
   endtask
`endif

   task automatic test_back_to_back();
      int k;
      int cyc;
      int sr_low;
      int mv_hi;
      logic was_ready;
      exp_q.delete();
      for (int i = 0; i < E; i++) exp_q.push_back(32'h0000_0100 + i);
      for (int i = 0; i < E; i++) exp_q.push_back(32'h0000_0200 + i);
      for (int i = 0; i < E; i++) exp_q.push_back(32'hFFFF_FFFF ^ i);
      for (int i = 0; i < E; i++) exp_q.push_back(32'(i) << 20);
      k = 0; cyc = 0; sr_low = 0; mv_hi = 0;
      bus.m_ready = 1'b1;
      while (k < 4*E && cyc < 200) begin
         bus.s_valid = 1'b1;
         bus.s_data  = exp_q[k];
`ifdef MATRIX_LOADER_FRAME_CHECK_EN
         bus.s_last  = (k % (2*E) == 2*E-1);
`endif
         was_ready = bus.s_ready;
         if (bus.m_valid) mv_hi++;
         if (!bus.s_ready) sr_low++;
         @(posedge clk); #1;
         cyc++;
         if (was_ready) begin
            if (k % (2*E) < E) mdl_a[(k % (2*E))*N +: N] = exp_q[k];
            else               mdl_b[(k % (2*E) - E)*N +: N] = exp_q[k];
            k++;
         end
      end
      bus.s_valid = 1'b0;
`ifdef MATRIX_LOADER_FRAME_CHECK_EN
      bus.s_last  = 1'b0;
`endif
      n_cmp++; if (k !== 4*E) begin n_fail++; $display("FAIL b2b_timeout beats=%0d exp %0d", k, 4*E); end
      n_cmp++; if (cyc !== 4*E+1) begin n_fail++; $display("FAIL b2b_cycles got %0d exp %0d", cyc, 4*E+1); end
      n_cmp++; if (sr_low !== 1) begin n_fail++; $display("FAIL b2b_s_ready_gap got %0d exp 1", sr_low); end
      n_cmp++; if (mv_hi !== 1) begin n_fail++; $display("FAIL b2b_m_valid_first got %0d exp 1", mv_hi); end
      n_cmp++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_m_valid_second got %b exp 1", bus.m_valid); end
      n_cmp++; if (bus.A !== mdl_a) begin n_fail++; $display("FAIL b2b_A got %h exp %h", bus.A, mdl_a); end
      n_cmp++; if (bus.B !== mdl_b) begin n_fail++; $display("FAIL b2b_B got %h exp %h", bus.B, mdl_b); end
      @(posedge clk); #1;
      n_cmp++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_m_valid_drop got %b exp 0", bus.m_valid); end
      n_cmp++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_s_ready_back got %b exp 1", bus.s_ready); end
      bus.m_ready = 1'b0;
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.m_ready = 1'b0;
`ifdef MATRIX_LOADER_FRAME_CHECK_EN
      bus.s_last  = 1'b0;
`endif
      test_reset();
      test_identity();
      test_hold();
      test_gaps();
      test_reset_mid();
`ifdef MATRIX_LOADER_FRAME_CHECK_EN
      test_frame_check();
`endif
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog run did not complete");
      $fatal(1, "watchdog");
   end
endmodule
